// File: rtl/adc_scan_sequencer_if.sv
// ============================================================================
//  Module   : adc_scan_sequencer_if
//  Brief    : Conversion-side and result-side signal bundle for the ADC scan
//             sequencer. The master modport is the sequencer. The slave
//             modport is the converter plus the result consumer.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface adc_scan_sequencer_if;
  // Conversion interface
  logic [1:0]  adc_mux;
  logic        adc_start;
  logic        adc_ready;
  logic [15:0] adc_data;
  // Result stream (valid/ready)
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_ch;

  modport master (
    output adc_mux, adc_start, res_valid, res_data, res_ch,
    input  adc_ready, adc_data, res_ready
  );

  modport slave (
    input  adc_mux, adc_start, res_valid, res_data, res_ch,
    output adc_ready, adc_data, res_ready
  );
endinterface

`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
// ============================================================================
//  Module   : adc_scan_sequencer
//  Brief    : Round-robin scanner over up to four ADC mux channels. For each
//             channel it selects the mux, waits a settling time, requests a
//             conversion, captures the result and hands it downstream over a
//             valid/ready handshake. A conversion that never completes raises
//             a sticky timeout flag.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adc_scan_sequencer #(
  parameter int TIMEOUT = 64           // WAIT cycles before abort, 2..255
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             scan_en,
  input  wire logic [3:0]       ch_mask,
  input  wire logic [7:0]       settle_cycles,
  input  wire logic             err_clr,
  adc_scan_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  timeout_err
);

  // Last counter value in WAIT before the conversion is abandoned. The
  // counter starts at 0 in the first WAIT cycle. The abort therefore happens
  // after exactly TIMEOUT WAIT cycles without adc_ready.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_ch;
  logic [1:0]  next_ch;
  logic [7:0]  settle_cnt;
  logic [7:0]  tmo_cnt;
  logic        sel;
  logic        capture;
  logic        handshake;
  logic        tmo_hit;

  // First enabled channel strictly after 'last', wrapping 3->0. The loop runs
  // from the farthest candidate to the nearest, so the nearest one wins. The
  // farthest candidate (offset 4) is 'last' itself. A lone enabled channel
  // therefore selects itself again.
  function automatic logic [1:0] pick_next(input logic [1:0] last,
                                           input logic [3:0] mask);
    logic [1:0] cand;
    pick_next = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (mask[cand]) pick_next = cand;
    end
  endfunction

  // Candidate channel for the next selection.
  always_comb begin
    next_ch = pick_next(last_ch, ch_mask);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, datapath strobes and state-decoded outputs.
  always_comb begin
    state_nxt     = S_IDLE;
    sel           = 1'b0;
    capture       = 1'b0;
    handshake     = 1'b0;
    tmo_hit       = 1'b0;
    bus.adc_start = 1'b0;
    busy          = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_en && (ch_mask != 4'd0)) begin
          sel       = 1'b1;
          state_nxt = S_SETTLE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        // A count of 0 or 1 both leave SETTLE after its first cycle.
        state_nxt = (settle_cnt <= 8'd1) ? S_START : S_SETTLE;
      end
      S_START: begin
        busy          = 1'b1;
        bus.adc_start = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus.adc_ready) begin
          capture   = 1'b1;
          state_nxt = S_OUTPUT;
        end else if (tmo_cnt == c_tmo_last) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_OUTPUT: begin
        busy = 1'b1;
        // res_valid is always high in OUTPUT, so res_ready alone completes it.
        if (bus.res_ready) begin
          handshake = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_OUTPUT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Channel selection, counters, result capture and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ch       <= 2'd3;
      bus.adc_mux   <= 2'd0;
      settle_cnt    <= 8'd0;
      tmo_cnt       <= 8'd0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= 16'd0;
      bus.res_ch    <= 2'd0;
      timeout_err   <= 1'b0;
    end else begin
      // The channel counts as sampled as soon as it is selected. A timeout
      // therefore still advances the scan.
      if (sel) begin
        last_ch     <= next_ch;
        bus.adc_mux <= next_ch;
        settle_cnt  <= settle_cycles;
      end else if ((state == S_SETTLE) && (settle_cnt != 8'd0)) begin
        settle_cnt <= settle_cnt - 8'd1;
      end

      if (state == S_START)     tmo_cnt <= 8'd0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 8'd1;

      if (capture) begin
        bus.res_data  <= bus.adc_data;
        bus.res_ch    <= bus.adc_mux;
        bus.res_valid <= 1'b1;
      end else if (handshake) begin
        bus.res_valid <= 1'b0;
      end

      // A timeout in the same cycle as err_clr leaves the flag set.
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire
